// File: rtl/divisor_frecuencia_multi.sv
// Multi-channel clock-enable generator.
// Each channel divides reloj by its own runtime-programmable divisor. It produces
// a one-cycle tick enable and a 50%-duty square wave whose period is 2*eff cycles.
// Priority on every edge, highest first: reset > sincronizar > write > count.
module divisor_frecuencia_multi #(
   parameter int NCH         = 3,
   parameter int WIDTH       = 17,
   parameter int SELW        = 2,
   parameter int DEFAULT_DIV = 125000
) (
   input  logic             reloj,
   input  logic             reset,
   input  logic [NCH-1:0]   habilitar,
   input  logic             sincronizar,
   input  logic             we,
   input  logic [SELW-1:0]  sel,
   input  logic [WIDTH-1:0] dato,
   output logic [NCH-1:0]   tick,
   output logic [NCH-1:0]   cuadrada
);

   logic [WIDTH-1:0] cnt_q [NCH];
   logic [WIDTH-1:0] cnt_d [NCH];
   logic [WIDTH-1:0] div_q [NCH];
   logic [WIDTH-1:0] div_d [NCH];
   logic [NCH-1:0]   tick_q, tick_d;
   logic [NCH-1:0]   cuadrada_q, cuadrada_d;

   // Per-channel helpers: write address match and terminal count (eff-1)
   logic [NCH-1:0]   wr_hit;
   logic [WIDTH-1:0] last_cnt [NCH];

   // Decode the write target and the terminal count of each channel
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         // A sel value of NCH or above never matches a channel. The write is then dropped.
         wr_hit[i]   = we && (sel == SELW'(i));
         // Divisors 0 and 1 both mean "divide by one". The terminal count is then 0.
         last_cnt[i] = (div_q[i] <= WIDTH'(1)) ? '0 : div_q[i] - WIDTH'(1);
      end
   end

   // Next-state logic for every channel. Reset is applied in the register block.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         // NOTE: every _d gets a hold/idle default before any branch, so no path can infer a latch.
         cnt_d[i]      = cnt_q[i];
         div_d[i]      = div_q[i];
         tick_d[i]     = 1'b0;
         cuadrada_d[i] = cuadrada_q[i];

         if (sincronizar) begin
            // Phase-align all channels. A coincident write still lands in its divisor.
            cnt_d[i]      = '0;
            cuadrada_d[i] = 1'b0;
            if (wr_hit[i]) begin
               div_d[i] = dato;
            end
         end else if (wr_hit[i]) begin
            // A new divisor restarts the period. The square-wave level is kept.
            div_d[i] = dato;
            cnt_d[i] = '0;
         end else if (habilitar[i]) begin
            // The >= compare also recovers a count left above a freshly lowered divisor.
            if (cnt_q[i] >= last_cnt[i]) begin
               cnt_d[i]      = '0;
               tick_d[i]     = 1'b1;
               cuadrada_d[i] = ~cuadrada_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + WIDTH'(1);
            end
         end
      end
   end

   // State registers with synchronous reset. Divisors return to DEFAULT_DIV.
   always_ff @(posedge reloj) begin
      // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            // NOTE: the divisor array is reset too. It holds live configuration, not bulk data.
            cnt_q[i] <= '0;
            div_q[i] <= WIDTH'(DEFAULT_DIV);
         end
         tick_q     <= '0;
         cuadrada_q <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
            div_q[i] <= div_d[i];
         end
         tick_q     <= tick_d;
         cuadrada_q <= cuadrada_d;
      end
   end

   assign tick     = tick_q;
   assign cuadrada = cuadrada_q;

endmodule

// File: tb/tb_divisor_frecuencia_multi.sv
// Scoreboard bench for divisor_frecuencia_multi (NCH=3, WIDTH=8, DEFAULT_DIV=4).
// The driver applies one input vector per cycle and advances a behavioural model.
// It pushes the expected outputs for that edge into a queue. A monitor pops
// each entry after the edge and compares it with the DUT outputs.
module tb_divisor_frecuencia_multi;

   localparam int NCH   = 3;
   localparam int WIDTH = 8;
   localparam int SELW  = 2;
   localparam int DDIV  = 4;

   logic             reloj = 1'b0;
   logic             reset = 1'b1;
   logic [NCH-1:0]   habilitar = '0;
   logic             sincronizar = 1'b0;
   logic             we = 1'b0;
   logic [SELW-1:0]  sel = '0;
   logic [WIDTH-1:0] dato = '0;
   logic [NCH-1:0]   tick;
   logic [NCH-1:0]   cuadrada;

   divisor_frecuencia_multi #(
      .NCH(NCH), .WIDTH(WIDTH), .SELW(SELW), .DEFAULT_DIV(DDIV)
   ) dut (
      .reloj(reloj), .reset(reset), .habilitar(habilitar),
      .sincronizar(sincronizar), .we(we), .sel(sel), .dato(dato),
      .tick(tick), .cuadrada(cuadrada)
   );

   always #5 reloj = ~reloj;

   typedef struct {
      logic [NCH-1:0] tick;
      logic [NCH-1:0] sq;
      int             scen;
      int             cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   scen     = 0;
   int   cyc      = 0;

   // Reference model. Per channel it tracks how many enabled edges have elapsed
   // in the current period, the divisor, and how many periods have completed
   // since the last clear. The square wave is the parity of that period count.
   int m_elapsed [NCH];
   int m_div     [NCH];
   int m_periods [NCH];
   bit m_tick    [NCH];

   task automatic model_edge(input bit r, input bit [NCH-1:0] h, input bit s,
                             input bit w, input bit [SELW-1:0] sl, input bit [WIDTH-1:0] d);
      for (int i = 0; i < NCH; i++) begin
         bit hit;
         int eff;
         hit = w && (int'(sl) == i);
         m_tick[i] = 1'b0;
         if (r) begin
            m_elapsed[i] = 0;
            m_div[i]     = DDIV;
            m_periods[i] = 0;
         end else if (s) begin
            m_elapsed[i] = 0;
            m_periods[i] = 0;
            if (hit) m_div[i] = int'(d);
         end else if (hit) begin
            m_div[i]     = int'(d);
            m_elapsed[i] = 0;
         end else if (h[i]) begin
            eff = (m_div[i] < 2) ? 1 : m_div[i];
            if (m_elapsed[i] + 1 >= eff) begin
               m_elapsed[i] = 0;
               m_tick[i]    = 1'b1;
               m_periods[i] = m_periods[i] + 1;
            end else begin
               m_elapsed[i] = m_elapsed[i] + 1;
            end
         end
      end
   endtask

   // Drive one cycle of inputs at the falling edge and queue the expected outputs
   task automatic step(input bit r, input bit [NCH-1:0] h, input bit s,
                       input bit w, input bit [SELW-1:0] sl, input bit [WIDTH-1:0] d);
      exp_t e;
      @(negedge reloj);
      reset = r; habilitar = h; sincronizar = s; we = w; sel = sl; dato = d;
      model_edge(r, h, s, w, sl, d);
      cyc = cyc + 1;
      for (int i = 0; i < NCH; i++) begin
         e.tick[i] = m_tick[i];
         e.sq[i]   = m_periods[i][0];
      end
      e.scen = scen;
      e.cyc  = cyc;
      exp_q.push_back(e);
   endtask

   task automatic run(input int n, input bit [NCH-1:0] h);
      repeat (n) step(1'b0, h, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      step(1'b1, '0, 1'b0, 1'b0, '0, '0);
      step(1'b1, '0, 1'b0, 1'b0, '0, '0);
   endtask

   // Monitor: compare every queued expectation just after the rising edge it describes
   initial begin
      exp_t e;
      forever begin
         @(posedge reloj);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (tick === e.tick) n_pass++;
            else $display("FAIL tick scen=%0d cyc=%0d got=%b want=%b", e.scen, e.cyc, tick, e.tick);
            n_checks++;
            if (cuadrada === e.sq) n_pass++;
            else $display("FAIL cuadrada scen=%0d cyc=%0d got=%b want=%b", e.scen, e.cyc, cuadrada, e.sq);
         end
      end
   end

   // Stimulus: directed scenarios followed by randomized traffic
   initial begin
      int wait_cycles;
      for (int i = 0; i < NCH; i++) begin
         m_elapsed[i] = 0; m_div[i] = DDIV; m_periods[i] = 0; m_tick[i] = 1'b0;
      end

      // 1: reset state, then free-running with default divisor 4
      scen = 1;
      do_reset();
      run(14, 3'b111);

      // 2: rewrite ch1 to 10 when its count is 2
      scen = 2;
      do_reset();
      run(2, 3'b111);
      step(1'b0, 3'b111, 1'b0, 1'b1, 2'd1, 8'd10);
      run(24, 3'b111);

      // 3: divisor 0 and 1 on ch2, then an out-of-range write
      scen = 3;
      step(1'b0, 3'b111, 1'b0, 1'b1, 2'd2, 8'd0);
      run(6, 3'b111);
      step(1'b0, 3'b111, 1'b0, 1'b1, 2'd2, 8'd1);
      run(6, 3'b111);
      step(1'b0, 3'b111, 1'b0, 1'b1, 2'd3, 8'd7);
      run(12, 3'b111);

      // 4: pause ch0 for 5 cycles at count 2, then resume
      scen = 4;
      do_reset();
      run(2, 3'b111);
      run(5, 3'b110);
      run(8, 3'b111);

      // 5: skew the phases, then align with sincronizar
      scen = 5;
      do_reset();
      run(1, 3'b001);
      run(2, 3'b011);
      run(3, 3'b111);
      step(1'b0, 3'b111, 1'b1, 1'b0, '0, '0);
      run(12, 3'b111);

      // 6: reset coinciding with a write while ch0 sits at its terminal count
      scen = 6;
      do_reset();
      run(3, 3'b111);
      step(1'b1, 3'b111, 1'b0, 1'b1, 2'd0, 8'd9);
      run(10, 3'b111);

      // 7: randomized traffic, including sincronizar plus write in the same cycle
      scen = 7;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         bit r, s, w;
         r = ($urandom_range(0, 99) < 2);
         s = ($urandom_range(0, 99) < 4);
         w = ($urandom_range(0, 99) < 12);
         step(r, 3'($urandom_range(0, 7)), s, w, 2'($urandom_range(0, 3)),
              8'($urandom_range(0, 12)));
      end
      run(3, 3'b111);

      // Drain the scoreboard within a bounded number of cycles
      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 10) begin
         @(posedge reloj);
         #2;
         wait_cycles++;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain got=%0d pending want=0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/divisor_frecuencia_multi.md
Name: divisor_frecuencia_multi

Overview:
Parametrised multi-channel clock-enable generator for the alarm-clock datapath. It replaces the fixed single-output dividers. Each of NCH channels divides the system clock by its own runtime-programmable divisor and produces two outputs: a one-cycle tick enable and a 50%-duty square wave (period 2*DIV). Typical uses are the display-multiplex rate, the seconds tick and the blink rate for time setting. All channels run in the single system clock domain.

Parameters:
NCH, 3, number of independent divider channels (1..4)
WIDTH, 17, width of each counter and divisor register
SELW, 2, width of channel-select field (>= clog2(NCH), minimum 1)
DEFAULT_DIV, 125000, divisor loaded into every channel at reset (must fit in WIDTH)

Ports:
reloj  in  1  system clock, all logic on rising edge
reset  in  1  synchronous reset, active-high
habilitar  in  NCH  per-channel count enable; bit i controls channel i
sincronizar  in  1  synchronous phase-align of all channels
we  in  1  divisor write strobe
sel  in  SELW  channel index for write
dato  in  WIDTH  new divisor value
tick  out  NCH  one-cycle pulse per channel, registered
cuadrada  out  NCH  square wave per channel, registered

Behaviour:
- Per-channel state: cnt[i] (WIDTH bits), div[i] (WIDTH bits), tick[i], cuadrada[i]. All outputs are registered; there is no combinational path from inputs to outputs.
- Priority per edge, highest first: reset > sincronizar > write > count.
- Reset (reset=1 at edge): cnt=0, div=DEFAULT_DIV, tick=0, cuadrada=0 for all channels. Reset mid-count discards the phase. Reset mid-write discards the write.
- sincronizar=1: every cnt=0, tick=0, cuadrada=0, regardless of habilitar. A write in the same cycle still updates div[sel].
- Write (we=1, sel<NCH): div[sel]<=dato and cnt[sel]<=0. tick[sel]=0 that cycle. cuadrada[sel] holds. Other channels count normally.
- Write with sel>=NCH: ignored, no state changes.
- Effective divisor: eff = 1 if div is 0 or 1, else div.
- Count (habilitar[i]=1, no higher-priority event on channel i):
  - if cnt[i] >= eff-1: cnt[i]<=0, tick[i]<=1, cuadrada[i] toggles.
  - otherwise: cnt[i]<=cnt[i]+1, tick[i]<=0.
  - The >= comparison handles a divisor reduced below the current count. Wrap is to 0; the counter never overflows WIDTH.
- Timing: with habilitar high continuously from reset release, tick first goes high after edge number eff and then every eff cycles. Tick is high for exactly one cycle. cuadrada period is 2*eff cycles with 50% duty.
- eff=1: tick is held high continuously and cuadrada toggles every cycle (reloj/2).
- habilitar[i]=0: cnt[i] and cuadrada[i] hold, tick[i]=0. When re-enabled, counting resumes from the held cnt.
- Channels are fully independent except for the shared reset and sincronizar.

Test Plan:
Bench config for all scenarios: NCH=3, WIDTH=8, DEFAULT_DIV=4.
1. Reset release, habilitar=111 -> all ticks high after edges 4, 8, 12 (one cycle each); cuadrada=1 after edge 4, 0 after edge 8.
2. Write ch1 dato=10 mid-count (cnt1=2) -> cnt1=0 and tick1 low that cycle; next tick1 10 edges later; ch0 and ch2 unaffected.
3. dato=0 to ch2, then dato=1 -> tick2 stuck high and cuadrada2 toggles every cycle in both cases; write with sel=3 -> no div changes.
4. habilitar[0] low for 5 cycles at cnt0=2 -> tick0 stays 0 and cuadrada0 holds; after re-enable, tick0 occurs 2 edges later.
5. Channels at different phases, then sincronizar=1 for one cycle -> all cnt, tick and cuadrada =0; the following ticks are phase-aligned for equal divisors.
6. reset asserted with we=1 and a channel at cnt=eff-1 -> div returns to 4 (write lost), no tick, cuadrada=0; first tick after release at edge 4.
